// File: rtl/multicycle_control_if.sv
// Shared memory port between the multicycle sequencer and the memory system.
// One outstanding request at a time; memReady completes it.
interface multicycle_control_if;
   logic        memReady;
   logic [31:0] memReadData;
   logic [31:0] memAddr;
   logic        memRead;
   logic        memWrite;
   logic [3:0]  memWriteMask;
   logic [31:0] memWriteData;

   modport master (
      input  memReady,
      input  memReadData,
      output memAddr,
      output memRead,
      output memWrite,
      output memWriteMask,
      output memWriteData
   );

   modport slave (
      output memReady,
      output memReadData,
      input  memAddr,
      input  memRead,
      input  memWrite,
      input  memWriteMask,
      input  memWriteData
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer: owns pc and the instruction register, walks each
// instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared
// memory port, extracts load data, aligns store data and halts on EBREAK,
// unknown opcodes or misaligned addresses/targets.
module multicycle_control #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                        CLK,
   input  logic                        RESET,
   multicycle_control_if.master        mem,
   input  logic [31:0]                 aluResult,
   input  logic                        branchTaken,
   input  logic [31:0]                 rs2Value,
   output logic [31:0]                 instruction,
   output logic [31:0]                 pc,
   output logic [31:0]                 loadData,
   output logic                        regWriteEnable,
   output logic [1:0]                  regWriteSelect,
   output logic [2:0]                  state,
   output logic                        halted,
   output logic                        fault
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   state_t      cur_state, nxt_state;
   // Held low through reset and for the first edge after release, so the first
   // fetch request appears one edge after release and reset kills requests
   // combinationally.
   logic        run;
   logic        ir_we, ld_we, pc_we, fault_set;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_op, is_opimm, is_lui, is_auipc;
   logic        is_jal, is_jalr, is_branch, is_fence, is_system, is_ebreak;
   logic        known_op, writes_rd;
   logic        f3_ok, ls_misaligned, ls_fault;
   logic [31:0] j_imm, b_imm, target_pc;
   logic [31:0] rd_shift_b, rd_shift_h, load_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [3:0]  st_mask;
   logic [31:0] st_data;

   assign opcode    = instruction[6:0];
   assign funct3    = instruction[14:12];
   assign is_load   = (opcode == 7'b0000011);
   assign is_store  = (opcode == 7'b0100011);
   assign is_op     = (opcode == 7'b0110011);
   assign is_opimm  = (opcode == 7'b0010011);
   assign is_lui    = (opcode == 7'b0110111);
   assign is_auipc  = (opcode == 7'b0010111);
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_branch = (opcode == 7'b1100011);
   assign is_fence  = (opcode == 7'b0001111);
   assign is_system = (opcode == 7'b1110011);
   assign is_ebreak = (instruction == 32'h0010_0073);

   assign known_op  = is_load | is_store | is_op | is_opimm | is_lui | is_auipc |
                      is_jal | is_jalr | is_branch | is_fence | is_system;
   assign writes_rd = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr | is_load;

   assign j_imm = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
   assign b_imm = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};

   assign state  = cur_state;
   assign halted = (cur_state == ST_HALT);

   // Write-source select follows the opcode class.
   always_comb begin
      regWriteSelect = 2'd0;
      if (is_load)                 regWriteSelect = 2'd1;
      else if (is_jal || is_jalr)  regWriteSelect = 2'd2;
      else if (is_lui || is_auipc) regWriteSelect = 2'd3;
   end

   // Load/store legality: funct3 must name a real access and the address must
   // be naturally aligned for its size; a bad access halts before any request.
   always_comb begin
      if (is_load) f3_ok = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      else         f3_ok = funct3 inside {3'd0, 3'd1, 3'd2};
      case (funct3[1:0])
         2'b00:   ls_misaligned = 1'b0;
         2'b01:   ls_misaligned = aluResult[0];
         2'b10:   ls_misaligned = |aluResult[1:0];
         default: ls_misaligned = 1'b1;
      endcase
      ls_fault = !f3_ok || ls_misaligned;
   end

   // Next-pc selection; 32-bit modulo arithmetic lets pc wrap to zero.
   always_comb begin
      target_pc = pc + 32'd4;
      if (is_jal)                        target_pc = pc + j_imm;
      else if (is_jalr)                  target_pc = aluResult & ~32'd1;
      else if (is_branch && branchTaken) target_pc = pc + b_imm;
   end

   // Load-data extraction: pick the addressed lane, then sign/zero extend.
   always_comb begin
      rd_shift_b = mem.memReadData >> {aluResult[1:0], 3'b000};
      rd_shift_h = mem.memReadData >> {aluResult[1], 4'b0000};
      ld_byte    = rd_shift_b[7:0];
      ld_half    = rd_shift_h[15:0];
      case (funct3)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'd0, ld_byte};
         3'b101:  load_ext = {16'd0, ld_half};
         default: load_ext = mem.memReadData;
      endcase
   end

   // Store alignment: data replicated into every lane, mask picks the target.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            st_mask = 4'b0001 << aluResult[1:0];
            st_data = {4{rs2Value[7:0]}};
         end
         2'b01: begin
            st_mask = 4'b0011 << {aluResult[1], 1'b0};
            st_data = {2{rs2Value[15:0]}};
         end
         default: begin
            st_mask = 4'b1111;
            st_data = rs2Value;
         end
      endcase
   end

   // Next-state, memory request and strobe generation.
   always_comb begin
      nxt_state        = cur_state;
      mem.memRead      = 1'b0;
      mem.memWrite     = 1'b0;
      mem.memAddr      = '0;
      mem.memWriteMask = '0;
      mem.memWriteData = '0;
      regWriteEnable   = 1'b0;
      ir_we            = 1'b0;
      ld_we            = 1'b0;
      pc_we            = 1'b0;
      fault_set        = 1'b0;
      case (cur_state)
         ST_FETCH: begin
            if (run) begin
               mem.memRead = 1'b1;
               mem.memAddr = pc;
               if (mem.memReady) begin
                  ir_we     = 1'b1;
                  nxt_state = ST_DECODE;
               end
            end
         end
         ST_DECODE: nxt_state = ST_EXECUTE;
         ST_EXECUTE: begin
            if (is_ebreak) begin
               nxt_state = ST_HALT;
            end else if (is_load || is_store) begin
               if (ls_fault) begin
                  fault_set = 1'b1;
                  nxt_state = ST_HALT;
               end else begin
                  nxt_state = ST_MEMORY;
               end
            end else if (known_op) begin
               nxt_state = ST_WRITEBACK;
            end else begin
               fault_set = 1'b1;
               nxt_state = ST_HALT;
            end
         end
         ST_MEMORY: begin
            mem.memAddr = {aluResult[31:2], 2'b00};
            if (is_load) begin
               mem.memRead = 1'b1;
            end else begin
               mem.memWrite     = 1'b1;
               mem.memWriteMask = st_mask;
               mem.memWriteData = st_data;
            end
            if (mem.memReady) begin
               ld_we     = is_load;
               nxt_state = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            if (|target_pc[1:0]) begin
               fault_set = 1'b1;
               nxt_state = ST_HALT;
            end else begin
               regWriteEnable = writes_rd;
               pc_we          = 1'b1;
               nxt_state      = ST_FETCH;
            end
         end
         ST_HALT: nxt_state = ST_HALT;
         default: begin
            fault_set = 1'b1;
            nxt_state = ST_HALT;
         end
      endcase
   end

   // State, pc, instruction and load registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cur_state   <= ST_FETCH;
         run         <= 1'b0;
         pc          <= RESET_PC;
         instruction <= '0;
         loadData    <= '0;
         fault       <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         run       <= 1'b1;
         if (ir_we)     instruction <= mem.memReadData;
         if (ld_we)     loadData    <= load_ext;
         if (pc_we)     pc          <= target_pc;
         if (fault_set) fault       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-encoded instructions, the bench
// plays the memory and datapath, and checks every cycle of interest.
module tb_multicycle_control;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] aluResult;
   logic        branchTaken;
   logic [31:0] rs2Value;
   logic [31:0] instruction, pc, loadData;
   logic        regWriteEnable;
   logic [1:0]  regWriteSelect;
   logic [2:0]  state;
   logic        halted, fault;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_control_if bus ();

   multicycle_control #(.RESET_PC(32'h0)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .mem            (bus),
      .aluResult      (aluResult),
      .branchTaken    (branchTaken),
      .rs2Value       (rs2Value),
      .instruction    (instruction),
      .pc             (pc),
      .loadData       (loadData),
      .regWriteEnable (regWriteEnable),
      .regWriteSelect (regWriteSelect),
      .state          (state),
      .halted         (halted),
      .fault          (fault)
   );

   always #5 CLK = ~CLK;

   localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_LB     = 32'h0000_0083; // lb   x1,0(x0)
   localparam logic [31:0] I_LHU    = 32'h0000_5083; // lhu  x1,0(x0)
   localparam logic [31:0] I_SB     = 32'h0000_0023; // sb
   localparam logic [31:0] I_SH     = 32'h0000_1023; // sh
   localparam logic [31:0] I_SW     = 32'h0000_2023; // sw
   localparam logic [31:0] I_JAL16  = 32'h0100_006F; // jal  x0,16
   localparam logic [31:0] I_JAL2   = 32'h0020_00EF; // jal  x1,2 (misaligned)
   localparam logic [31:0] I_BEQ8   = 32'h0000_0463; // beq  x0,x0,8
   localparam logic [31:0] I_JALR   = 32'h0000_00E7; // jalr x1,0(x0)
   localparam logic [31:0] I_EBREAK = 32'h0010_0073;
   localparam logic [31:0] I_BAD    = 32'h0000_007F;

   task automatic tick();
      @(negedge CLK);
   endtask

   // Hold reset two cycles, release on a falling edge, return in the first
   // fetch cycle (one rising edge after release).
   task automatic do_reset();
      RESET = 1'b0;
      bus.memReady = 1'b0; bus.memReadData = '0;
      aluResult = '0; branchTaken = 1'b0; rs2Value = '0;
      repeat (2) tick();
      RESET = 1'b1;
      tick();
   endtask

   // Zero-wait fetch of inst from the current FETCH cycle; returns in EXECUTE.
   task automatic issue(input logic [31:0] inst, input logic [31:0] alu, input logic br);
      aluResult = alu; branchTaken = br;
      bus.memReady = 1'b1; bus.memReadData = inst;
      tick();
      bus.memReady = 1'b0; bus.memReadData = '0;
      tick();
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.memReady = 1'b0; bus.memReadData = '0;
      aluResult = '0; branchTaken = 1'b0; rs2Value = '0;
      tick();
      if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end n_cmp++;
      if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end n_cmp++;
      if (instruction !== 32'h0 || loadData !== 32'h0) begin n_bad++; $display("FAIL reset_regs: ir %h ld %h want 0", instruction, loadData); end n_cmp++;
      if ({halted, fault} !== 2'b00) begin n_bad++; $display("FAIL reset_halt: got %b want 00", {halted, fault}); end n_cmp++;
      if ({bus.memRead, bus.memWrite, regWriteEnable, bus.memWriteMask} !== 7'd0) begin
         n_bad++; $display("FAIL reset_strobes: rd %b wr %b rwe %b mask %b want 0", bus.memRead, bus.memWrite, regWriteEnable, bus.memWriteMask);
      end n_cmp++;
      RESET = 1'b1;
      #1;
      if (bus.memRead !== 1'b0) begin n_bad++; $display("FAIL release_no_req: got %b want 0", bus.memRead); end n_cmp++;
      tick();
      if (bus.memRead !== 1'b1 || bus.memAddr !== 32'h0) begin
         n_bad++; $display("FAIL first_fetch: rd %b addr %h want 1 / 0", bus.memRead, bus.memAddr);
      end n_cmp++;
   endtask

   task automatic test_addi();
      do_reset();
      if (state !== 3'd0 || bus.memRead !== 1'b1) begin n_bad++; $display("FAIL addi_c0: state %0d rd %b want 0/1", state, bus.memRead); end n_cmp++;
      aluResult = 32'd5; bus.memReady = 1'b1; bus.memReadData = I_ADDI;
      tick();
      bus.memReady = 1'b0;
      if (state !== 3'd1 || instruction !== I_ADDI) begin n_bad++; $display("FAIL addi_c1: state %0d ir %h want 1/%h", state, instruction, I_ADDI); end n_cmp++;
      tick();
      if (state !== 3'd2 || regWriteEnable !== 1'b0) begin n_bad++; $display("FAIL addi_c2: state %0d rwe %b want 2/0", state, regWriteEnable); end n_cmp++;
      tick();
      if (state !== 3'd4 || regWriteEnable !== 1'b1 || regWriteSelect !== 2'd0) begin
         n_bad++; $display("FAIL addi_c3: state %0d rwe %b sel %0d want 4/1/0", state, regWriteEnable, regWriteSelect);
      end n_cmp++;
      tick();
      if (state !== 3'd0 || pc !== 32'd4 || regWriteEnable !== 1'b0) begin
         n_bad++; $display("FAIL addi_c4: state %0d pc %h rwe %b want 0/4/0", state, pc, regWriteEnable);
      end n_cmp++;
   endtask

   task automatic test_load();
      do_reset();
      issue(I_LB, 32'h103, 1'b0);
      tick(); // cycle 3, MEMORY, no ready yet
      if (state !== 3'd3 || bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.memAddr !== 32'h100) begin
         n_bad++; $display("FAIL lb_req: state %0d rd %b wr %b addr %h want 3/1/0/100", state, bus.memRead, bus.memWrite, bus.memAddr);
      end n_cmp++;
      tick(); // cycle 4, still waiting
      if (bus.memRead !== 1'b1 || bus.memAddr !== 32'h100) begin n_bad++; $display("FAIL lb_hold: rd %b addr %h want 1/100", bus.memRead, bus.memAddr); end n_cmp++;
      tick(); // cycle 5, ready
      bus.memReady = 1'b1; bus.memReadData = 32'h80FF_FFFF;
      tick(); // cycle 6, WRITEBACK
      bus.memReady = 1'b0; bus.memReadData = '0;
      if (state !== 3'd4 || loadData !== 32'hFFFF_FF80 || regWriteSelect !== 2'd1 || regWriteEnable !== 1'b1) begin
         n_bad++; $display("FAIL lb_wb: state %0d ld %h sel %0d rwe %b want 4/ffffff80/1/1", state, loadData, regWriteSelect, regWriteEnable);
      end n_cmp++;
      tick(); // cycle 7, next FETCH
      if (state !== 3'd0 || pc !== 32'd4) begin n_bad++; $display("FAIL lb_next: state %0d pc %h want 0/4", state, pc); end n_cmp++;
      issue(I_LHU, 32'h102, 1'b0);
      tick();
      bus.memReady = 1'b1; bus.memReadData = 32'h80FF_1234;
      tick();
      bus.memReady = 1'b0;
      if (loadData !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_data: got %h want 000080ff", loadData); end n_cmp++;
      tick();
      if (pc !== 32'd8) begin n_bad++; $display("FAIL lhu_pc: got %h want 8", pc); end n_cmp++;
   endtask

   task automatic test_store();
      logic saw_write;
      do_reset();
      rs2Value = 32'h0000_ABCD;
      issue(I_SH, 32'h102, 1'b0);
      tick(); // MEMORY, waiting one cycle
      if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 || bus.memWriteMask !== 4'b1100 || bus.memAddr !== 32'h100) begin
         n_bad++; $display("FAIL sh_req: wr %b rd %b mask %b addr %h want 1/0/1100/100", bus.memWrite, bus.memRead, bus.memWriteMask, bus.memAddr);
      end n_cmp++;
      if (bus.memWriteData[31:16] !== 16'hABCD) begin n_bad++; $display("FAIL sh_data: got %h want abcd", bus.memWriteData[31:16]); end n_cmp++;
      tick();
      if (bus.memWrite !== 1'b1 || bus.memWriteMask !== 4'b1100) begin n_bad++; $display("FAIL sh_hold: wr %b mask %b want 1/1100", bus.memWrite, bus.memWriteMask); end n_cmp++;
      bus.memReady = 1'b1;
      tick();
      bus.memReady = 1'b0;
      if (state !== 3'd4 || regWriteEnable !== 1'b0 || bus.memWrite !== 1'b0) begin
         n_bad++; $display("FAIL sh_wb: state %0d rwe %b wr %b want 4/0/0", state, regWriteEnable, bus.memWrite);
      end n_cmp++;
      tick();
      rs2Value = 32'h1234_5678;
      issue(I_SB, 32'h101, 1'b0);
      tick();
      if (bus.memWriteMask !== 4'b0010 || bus.memWriteData[15:8] !== 8'h78) begin
         n_bad++; $display("FAIL sb_lane: mask %b byte %h want 0010/78", bus.memWriteMask, bus.memWriteData[15:8]);
      end n_cmp++;
      bus.memReady = 1'b1;
      tick();
      bus.memReady = 1'b0;
      tick();
      // Misaligned SW: halts from EXECUTE, no write ever issued.
      do_reset();
      rs2Value = 32'hDEAD_BEEF;
      issue(I_SW, 32'h101, 1'b0);
      saw_write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         saw_write |= bus.memWrite;
         tick();
      end
      if (saw_write !== 1'b0) begin n_bad++; $display("FAIL sw_mis_nowrite: saw %b want 0", saw_write); end n_cmp++;
      if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b1) begin
         n_bad++; $display("FAIL sw_mis_halt: state %0d halted %b fault %b want 5/1/1", state, halted, fault);
      end n_cmp++;
   endtask

   task automatic test_branch();
      do_reset();
      issue(I_JAL16, 32'h0, 1'b0);
      tick();
      if (regWriteEnable !== 1'b1 || regWriteSelect !== 2'd2) begin n_bad++; $display("FAIL jal_wb: rwe %b sel %0d want 1/2", regWriteEnable, regWriteSelect); end n_cmp++;
      tick();
      if (pc !== 32'd16) begin n_bad++; $display("FAIL jal_pc: got %h want 10", pc); end n_cmp++;
      issue(I_BEQ8, 32'h0, 1'b1);
      tick();
      if (regWriteEnable !== 1'b0) begin n_bad++; $display("FAIL beq_rwe: got %b want 0", regWriteEnable); end n_cmp++;
      tick();
      if (pc !== 32'd24) begin n_bad++; $display("FAIL beq_taken_pc: got %h want 18", pc); end n_cmp++;
      do_reset();
      issue(I_JAL16, 32'h0, 1'b0);
      tick(); tick();
      issue(I_BEQ8, 32'h0, 1'b0);
      tick(); tick();
      if (pc !== 32'd20) begin n_bad++; $display("FAIL beq_nottaken_pc: got %h want 14", pc); end n_cmp++;
      do_reset();
      issue(I_JALR, 32'h201, 1'b0);
      tick();
      if (regWriteEnable !== 1'b1 || regWriteSelect !== 2'd2) begin n_bad++; $display("FAIL jalr_wb: rwe %b sel %0d want 1/2", regWriteEnable, regWriteSelect); end n_cmp++;
      tick();
      if (pc !== 32'h200) begin n_bad++; $display("FAIL jalr_pc: got %h want 200", pc); end n_cmp++;
   endtask

   task automatic test_wrap();
      do_reset();
      issue(I_JALR, 32'hFFFF_FFFC, 1'b0);
      tick(); tick();
      if (pc !== 32'hFFFF_FFFC || bus.memAddr !== 32'hFFFF_FFFC) begin
         n_bad++; $display("FAIL wrap_top: pc %h addr %h want fffffffc", pc, bus.memAddr);
      end n_cmp++;
      issue(I_ADDI, 32'd5, 1'b0);
      tick(); tick();
      if (pc !== 32'h0 || fault !== 1'b0) begin n_bad++; $display("FAIL wrap_zero: pc %h fault %b want 0/0", pc, fault); end n_cmp++;
   endtask

   task automatic test_ebreak();
      logic saw_req;
      logic left_halt;
      do_reset();
      issue(I_EBREAK, 32'h0, 1'b0);
      tick();
      if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b0) begin
         n_bad++; $display("FAIL ebreak_halt: state %0d halted %b fault %b want 5/1/0", state, halted, fault);
      end n_cmp++;
      saw_req = 1'b0; left_halt = 1'b0;
      bus.memReady = 1'b1; // stray ready must be ignored
      for (int i = 0; i < 20; i++) begin
         tick();
         saw_req   |= bus.memRead | bus.memWrite;
         left_halt |= (state !== 3'd5);
      end
      bus.memReady = 1'b0;
      if (saw_req !== 1'b0) begin n_bad++; $display("FAIL ebreak_noreq: saw %b want 0", saw_req); end n_cmp++;
      if (left_halt !== 1'b0) begin n_bad++; $display("FAIL ebreak_absorb: left %b want 0", left_halt); end n_cmp++;
   endtask

   task automatic test_faults();
      do_reset();
      issue(I_JAL2, 32'h0, 1'b0);
      tick();
      if (regWriteEnable !== 1'b0) begin n_bad++; $display("FAIL jal_mis_rwe: got %b want 0", regWriteEnable); end n_cmp++;
      tick();
      if (state !== 3'd5 || fault !== 1'b1 || pc !== 32'h0) begin
         n_bad++; $display("FAIL jal_mis_halt: state %0d fault %b pc %h want 5/1/0", state, fault, pc);
      end n_cmp++;
      do_reset();
      if (fault !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL fault_cleared: fault %b halted %b want 0/0", fault, halted); end n_cmp++;
      issue(I_BAD, 32'h0, 1'b0);
      tick();
      if (state !== 3'd5 || fault !== 1'b1) begin n_bad++; $display("FAIL badop_halt: state %0d fault %b want 5/1", state, fault); end n_cmp++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue(I_ADDI, 32'd5, 1'b0);
      tick(); tick(); // FETCH at pc 4, no ready
      tick();
      if (bus.memRead !== 1'b1 || bus.memAddr !== 32'd4) begin n_bad++; $display("FAIL mid_wait: rd %b addr %h want 1/4", bus.memRead, bus.memAddr); end n_cmp++;
      RESET = 1'b0;
      #1;
      if (bus.memRead !== 1'b0) begin n_bad++; $display("FAIL mid_abort: rd %b want 0", bus.memRead); end n_cmp++;
      if (pc !== 32'h0 || state !== 3'd0) begin n_bad++; $display("FAIL mid_pc: pc %h state %0d want 0/0", pc, state); end n_cmp++;
      tick();
      RESET = 1'b1;
      tick();
      if (bus.memRead !== 1'b1 || bus.memAddr !== 32'h0) begin n_bad++; $display("FAIL mid_restart: rd %b addr %h want 1/0", bus.memRead, bus.memAddr); end n_cmp++;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load();
      test_store();
      test_branch();
      test_wrap();
      test_ebreak();
      test_faults();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
